// File: rtl/mul16_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mul16_ctrl_pkg
// Brief  : Shared widths and state encoding for the shared 16-bit multiplier.
// Rev    : 1.0
// ============================================================================
package mul16_ctrl_pkg;

    localparam int WIDTH   = 16;
    localparam int c_CNT_W = 4;

    // 2'd3 is never entered; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/Multiplier16Bit.sv
`default_nettype none
// ============================================================================
// Module : Multiplier16Bit
// Brief  : Combinational unsigned 16x16 shift-and-add array multiplier.
// Rev    : 1.0
// ============================================================================
module Multiplier16Bit
    import mul16_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_p
);

    logic [2*WIDTH-1:0] w_acc;

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc + ({{WIDTH{1'b0}}, i_a} << i);
            end
        end
    end

    assign o_p = w_acc;

endmodule
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Combinational 2-way round-robin arbiter, grant is one-hot or zero.
// Rev    : 1.0
// ============================================================================
module rr_arb2
    import mul16_ctrl_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // On a tie the requester that did not win last time goes first.
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_id = grant[1];

endmodule
`default_nettype wire

// File: rtl/mul16_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mul16_share_ctrl
// Brief  : Shares one combinational 16-bit multiplier between two requesters.
// Rev    : 1.0
// ============================================================================
module mul16_share_ctrl
    import mul16_ctrl_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_phigh,
    output logic [WIDTH-1:0] rsp_plow,
    input  logic             rsp_ready,
    output logic             busy
);

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_op_a;
    logic [WIDTH-1:0]     r_op_b;
    logic                 r_id;
    logic                 r_last_grant;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [WIDTH-1:0]     r_rsp_phigh;
    logic [WIDTH-1:0]     r_rsp_plow;
    logic [1:0]           w_grant;
    logic                 w_grant_id;
    logic                 w_idle;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_rsp_done;
    logic [2*WIDTH-1:0]   w_prod;

    // The unreachable encoding behaves exactly like IDLE.
    assign w_idle     = (r_state != WAIT) && (r_state != HOLD);
    assign w_accept   = |w_grant;
    assign w_capture  = (r_state == WAIT) && (r_cnt == '0);
    assign w_rsp_done = (r_state == HOLD) && r_rsp_valid && rsp_ready;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (r_last_grant),
        .enable     (w_idle),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    Multiplier16Bit u_mul (
        .i_a (r_op_a),
        .i_b (r_op_b),
        .o_p (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? WAIT : IDLE;
            WAIT:    w_next_state = w_capture ? HOLD : WAIT;
            HOLD:    w_next_state = w_rsp_done ? IDLE : HOLD;
            default: w_next_state = w_accept ? WAIT : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_phigh  <= '0;
            r_rsp_plow   <= '0;
        end else begin
            if (w_accept) begin
                r_op_a       <= w_grant_id ? req1_a : req0_a;
                r_op_b       <= w_grant_id ? req1_b : req0_b;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_cnt        <= c_CNT_W'(SETTLE_CYCLES - 1);
            end
            if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Operands have been stable for SETTLE_CYCLES full cycles here.
            if (w_capture) begin
                r_rsp_phigh <= w_prod[2*WIDTH-1:WIDTH];
                r_rsp_plow  <= w_prod[WIDTH-1:0];
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_phigh  = r_rsp_phigh;
    assign rsp_plow   = r_rsp_plow;
    assign busy       = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mul16_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mul16_share_ctrl
// Brief  : Self-checking bench for mul16_share_ctrl against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_mul16_share_ctrl;

    localparam int S = 2;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_phigh;
    logic [15:0] rsp_plow;
    logic        rsp_ready;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int both_ready_cnt    = 0;
    int ready_in_hold_cnt = 0;
    bit model_last;
    bit engine_timeout;

    int          acc_cyc[$];
    bit          acc_id[$];
    bit          acc_v0[$];
    bit          acc_v1[$];
    logic [15:0] acc_a[$];
    logic [15:0] acc_b[$];
    int          rsp_cyc[$];
    int          rsp_len[$];
    int          rsp_chg[$];
    bit          rsp_idq[$];
    logic [31:0] rsp_prod[$];

    mul16_share_ctrl #(.WIDTH(16), .SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_phigh  (rsp_phigh),
        .rsp_plow   (rsp_plow),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req0_ready && req1_ready) both_ready_cnt++;
        if (rsp_valid && (req0_ready || req1_ready)) ready_in_hold_cnt++;
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_last = 1'b1;
    endtask

    // Drives n0/n1 transactions (valid held high until all are accepted) and
    // records every accept and every response handshake; no checking here.
    task automatic run_traffic(input int n0, input int n1,
                               input logic [15:0] a0, input logic [15:0] b0,
                               input logic [15:0] a1, input logic [15:0] b1,
                               input int bp, input bit rnd);
        int rem0 = n0;
        int rem1 = n1;
        int seen = 0;
        int budget = 0;
        int first_cyc = 0;
        int chg = 0;
        logic [31:0] first_p = '0;
        bit first_id = 1'b0;
        bit got0, got1;
        acc_cyc.delete(); acc_id.delete(); acc_v0.delete(); acc_v1.delete();
        acc_a.delete(); acc_b.delete();
        rsp_cyc.delete(); rsp_len.delete(); rsp_chg.delete(); rsp_idq.delete(); rsp_prod.delete();
        engine_timeout = 1'b0;
        @(posedge clk); #1;
        req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
        req0_valid = (rem0 > 0);
        req1_valid = (rem1 > 0);
        rsp_ready  = (bp == 0);
        while (rsp_idq.size() < n0 + n1) begin
            if (budget++ > 600) begin
                engine_timeout = 1'b1;
                break;
            end
            @(negedge clk);
            got0 = req0_ready;
            got1 = req1_ready;
            if (got0 || got1) begin
                acc_cyc.push_back(cyc);
                acc_id.push_back(got1);
                acc_v0.push_back(req0_valid);
                acc_v1.push_back(req1_valid);
                acc_a.push_back(got1 ? req1_a : req0_a);
                acc_b.push_back(got1 ? req1_b : req0_b);
            end
            if (rsp_valid) begin
                seen++;
                if (seen == 1) begin
                    first_p = {rsp_phigh, rsp_plow};
                    first_id = rsp_id;
                    first_cyc = cyc;
                    chg = 0;
                end else if ({rsp_phigh, rsp_plow} !== first_p || rsp_id !== first_id) begin
                    chg++;
                end
                rsp_ready = (seen > bp);
                if (rsp_ready) begin
                    rsp_cyc.push_back(first_cyc);
                    rsp_len.push_back(seen);
                    rsp_chg.push_back(chg);
                    rsp_idq.push_back(first_id);
                    rsp_prod.push_back(first_p);
                    seen = 0;
                end
            end
            @(posedge clk); #1;
            if (got0) begin
                rem0--;
                if (rem0 > 0) begin
                    if (rnd) begin req0_a = 16'($urandom); req0_b = 16'($urandom); end
                end else req0_valid = 1'b0;
            end
            if (got1) begin
                rem1--;
                if (rem1 > 0) begin
                    if (rnd) begin req1_a = 16'($urandom); req1_b = 16'($urandom); end
                end else req1_valid = 1'b0;
            end
            if (seen == 0) rsp_ready = (bp == 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id: got %b exp 0", rsp_id); end
        vectors++; if ({rsp_phigh, rsp_plow} !== 32'h0) begin miscompares++; $display("FAIL reset_product: got %h exp 0", {rsp_phigh, rsp_plow}); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", busy); end
        vectors++; if ({req1_ready, req0_ready} !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b exp 00", {req1_ready, req0_ready}); end
    endtask

    task automatic test_single();
        apply_reset();
        run_traffic(1, 0, 16'd152, 16'd2773, 16'd0, 16'd0, 0, 1'b0);
        vectors++; if (engine_timeout !== 1'b0) begin miscompares++; $display("FAIL single_timeout: got %b exp 0", engine_timeout); end
        if (!engine_timeout) begin
            vectors++; if (acc_id[0] !== 1'b0) begin miscompares++; $display("FAIL single_grant: got %b exp 0", acc_id[0]); end
            vectors++; if (rsp_cyc[0] - acc_cyc[0] !== S + 1) begin miscompares++; $display("FAIL single_latency: got %0d exp %0d", rsp_cyc[0] - acc_cyc[0], S + 1); end
            vectors++; if (rsp_idq[0] !== 1'b0) begin miscompares++; $display("FAIL single_id: got %b exp 0", rsp_idq[0]); end
            vectors++; if (rsp_prod[0] !== 32'h0006_6E78) begin miscompares++; $display("FAIL single_product: got %h exp 00066e78", rsp_prod[0]); end
            @(negedge clk);
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b exp 0", busy); end
        end
    endtask

    task automatic test_simultaneous();
        int br0 = both_ready_cnt;
        apply_reset();
        run_traffic(1, 1, 16'd3, 16'd5, 16'd7, 16'd9, 0, 1'b0);
        vectors++; if (engine_timeout !== 1'b0) begin miscompares++; $display("FAIL simul_timeout: got %b exp 0", engine_timeout); end
        if (!engine_timeout) begin
            vectors++; if ({acc_id[0], acc_id[1]} !== 2'b01) begin miscompares++; $display("FAIL simul_grant_order: got %b%b exp 01", acc_id[0], acc_id[1]); end
            vectors++; if (rsp_idq[0] !== 1'b0 || rsp_prod[0] !== 32'd15) begin miscompares++; $display("FAIL simul_rsp0: got id %b p %0d exp id 0 p 15", rsp_idq[0], rsp_prod[0]); end
            vectors++; if (rsp_idq[1] !== 1'b1 || rsp_prod[1] !== 32'd63) begin miscompares++; $display("FAIL simul_rsp1: got id %b p %0d exp id 1 p 63", rsp_idq[1], rsp_prod[1]); end
        end
        vectors++; if (both_ready_cnt - br0 !== 0) begin miscompares++; $display("FAIL simul_both_ready: got %0d cycles exp 0", both_ready_cnt - br0); end
        model_last = 1'b1;
    endtask

    task automatic test_fairness();
        bit exp_id;
        logic [31:0] exp_p;
        run_traffic(3, 3, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b1);
        vectors++; if (engine_timeout !== 1'b0 || acc_id.size() !== 6) begin miscompares++; $display("FAIL fair_count: got %0d accepts exp 6", acc_id.size()); end
        for (int i = 0; i < acc_id.size() && i < rsp_idq.size(); i++) begin
            exp_id = (acc_v0[i] && acc_v1[i]) ? ~model_last : acc_v1[i];
            model_last = exp_id;
            exp_p = 32'(acc_a[i]) * 32'(acc_b[i]);
            vectors++; if (acc_id[i] !== exp_id) begin miscompares++; $display("FAIL fair_grant[%0d]: got %b exp %b", i, acc_id[i], exp_id); end
            vectors++; if (rsp_idq[i] !== exp_id || rsp_prod[i] !== exp_p) begin miscompares++; $display("FAIL fair_rsp[%0d]: got id %b p %h exp id %b p %h", i, rsp_idq[i], rsp_prod[i], exp_id, exp_p); end
            if (i > 0) begin
                vectors++; if (acc_cyc[i] - acc_cyc[i-1] !== S + 2) begin miscompares++; $display("FAIL fair_spacing[%0d]: got %0d exp %0d", i, acc_cyc[i] - acc_cyc[i-1], S + 2); end
            end
        end
    endtask

    task automatic test_backpressure();
        int rh0 = ready_in_hold_cnt;
        apply_reset();
        run_traffic(1, 1, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h0002, 5, 1'b0);
        vectors++; if (engine_timeout !== 1'b0) begin miscompares++; $display("FAIL bp_timeout: got %b exp 0", engine_timeout); end
        if (!engine_timeout) begin
            vectors++; if (rsp_prod[0] !== 32'hFFFE_0001) begin miscompares++; $display("FAIL bp_product: got %h exp fffe0001", rsp_prod[0]); end
            vectors++; if (rsp_len[0] !== 6 || rsp_chg[0] !== 0) begin miscompares++; $display("FAIL bp_hold: got %0d cycles %0d changes exp 6 cycles 0 changes", rsp_len[0], rsp_chg[0]); end
            vectors++; if (rsp_idq[1] !== 1'b1 || rsp_prod[1] !== 32'h0000_2468) begin miscompares++; $display("FAIL bp_second: got id %b p %h exp id 1 p 00002468", rsp_idq[1], rsp_prod[1]); end
        end
        vectors++; if (ready_in_hold_cnt - rh0 !== 0) begin miscompares++; $display("FAIL bp_ready_in_hold: got %0d cycles exp 0", ready_in_hold_cnt - rh0); end
        rsp_ready = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_reset_in_wait();
        int n_valid = 0;
        bit got = 1'b0;
        @(posedge clk); #1;
        req1_a = 16'd100; req1_b = 16'd200; req1_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = req1_ready;
        end
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rstwait_accept: got %b exp 1", got); end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) n_valid++;
        end
        vectors++; if (n_valid !== 0) begin miscompares++; $display("FAIL rstwait_no_rsp: got %0d valid cycles exp 0", n_valid); end
        vectors++; if ({rsp_valid, rsp_id, rsp_phigh, rsp_plow, busy} !== 35'h0) begin miscompares++; $display("FAIL rstwait_outputs: got v%b id%b p%h busy%b exp all 0", rsp_valid, rsp_id, {rsp_phigh, rsp_plow}, busy); end
        model_last = 1'b1;
        run_traffic(0, 1, 16'd0, 16'd0, 16'd0, 16'd1234, 0, 1'b0);
        vectors++; if (engine_timeout !== 1'b0 || rsp_idq[0] !== 1'b1 || rsp_prod[0] !== 32'd0) begin miscompares++; $display("FAIL rstwait_after: got timeout %b id %b p %h exp 0 1 0", engine_timeout, rsp_idq[0], rsp_prod[0]); end
        model_last = 1'b1;
    endtask

    task automatic test_random();
        bit exp_id;
        logic [31:0] exp_p;
        for (int r = 0; r < 4; r++) begin
            run_traffic($urandom_range(1, 4), $urandom_range(1, 4),
                        16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                        $urandom_range(0, 2), 1'b1);
            vectors++; if (engine_timeout !== 1'b0) begin miscompares++; $display("FAIL rand_timeout[%0d]: got %b exp 0", r, engine_timeout); end
            for (int i = 0; i < acc_id.size() && i < rsp_idq.size(); i++) begin
                exp_id = (acc_v0[i] && acc_v1[i]) ? ~model_last : acc_v1[i];
                model_last = exp_id;
                exp_p = 32'(acc_a[i]) * 32'(acc_b[i]);
                vectors++; if (acc_id[i] !== exp_id) begin miscompares++; $display("FAIL rand_grant[%0d.%0d]: got %b exp %b", r, i, acc_id[i], exp_id); end
                vectors++; if (rsp_idq[i] !== exp_id || rsp_prod[i] !== exp_p) begin miscompares++; $display("FAIL rand_rsp[%0d.%0d]: got id %b p %h exp id %b p %h", r, i, rsp_idq[i], rsp_prod[i], exp_id, exp_p); end
                vectors++; if (rsp_cyc[i] - acc_cyc[i] !== S + 1) begin miscompares++; $display("FAIL rand_latency[%0d.%0d]: got %0d exp %0d", r, i, rsp_cyc[i] - acc_cyc[i], S + 1); end
            end
        end
        rsp_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        model_last = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
